// File: rtl/intc_arm_pkg.sv
// intc_arm_pkg: register map and constants shared by the interrupt controller and core-side drivers
package intc_arm_pkg;
  typedef enum logic [2:0] {
    INTC_REG_IRQ_STATUS,
    INTC_REG_FIQ_STATUS,
    INTC_REG_RAW,
    INTC_REG_ENABLE_SET,
    INTC_REG_ENABLE_CLR,
    INTC_REG_SELECT,
    INTC_REG_EDGE,
    INTC_REG_VECTOR
  } intc_reg_e;
  localparam logic [31:0] INTC_NO_VECTOR = 32'h8000_0000;
endpackage

// File: rtl/intc_source.sv
// intc_source: per-line synchroniser, rise detect and edge latch for one interrupt source
// Ports: src_i raw async line, edge_i edge-mode select, clr_i latch clear,
// raw_o level (synchronised line) or latched edge depending on edge_i.
module intc_source (
  input  logic clk,
  input  logic rst_n,
  input  logic src_i,
  input  logic edge_i,
  input  logic clr_i,
  output logic raw_o
);
  logic s1_q, s2_q, prev_q, latch_q, latch_d, rise;
  assign rise = s2_q & ~prev_q;
  // a rise on the same edge as a clear keeps the latch set
  assign latch_d = (latch_q & ~clr_i) | rise;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q    <= 1'b0;
      s2_q    <= 1'b0;
      prev_q  <= 1'b0;
      latch_q <= 1'b0;
    end else begin
      s1_q    <= src_i;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      latch_q <= latch_d;
    end
  end
  assign raw_o = edge_i ? latch_q : s2_q;
endmodule

// File: rtl/intc_arm.sv
// intc_arm: memory-mapped IRQ/FIQ interrupt controller with Avalon-MM slave
// Ports: sources async peripheral lines; avl_* Avalon-MM slave (read latency 1,
// no waitrequest); irq/fiq registered request levels to the core.
module intc_arm
  import intc_arm_pkg::*;
#(
  parameter int NUM_SOURCES = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SOURCES-1:0] sources,
  input  logic [2:0]             avl_address,
  input  logic                   avl_read,
  input  logic                   avl_write,
  input  logic [31:0]            avl_writedata,
  output logic [31:0]            avl_readdata,
  output logic                   irq,
  output logic                   fiq
);
  localparam int N = NUM_SOURCES;
  logic [N-1:0] enable_q, enable_d, select_q, select_d, edge_q, edge_d;
  logic [N-1:0] raw, clr, act_irq, act_fiq, wd;
  logic [31:0]  rdata_q, rdata_d, vector;
  logic [31:0]  rmux [8];
  logic         irq_q, fiq_q, vec_hit;
  logic [4:0]   vec_idx;
  logic         wr_set, wr_clr, wr_sel, wr_edge, wr_vec;
  assign wd      = avl_writedata[N-1:0];
  assign wr_set  = avl_write && avl_address == INTC_REG_ENABLE_SET;
  assign wr_clr  = avl_write && avl_address == INTC_REG_ENABLE_CLR;
  assign wr_sel  = avl_write && avl_address == INTC_REG_SELECT;
  assign wr_edge = avl_write && avl_address == INTC_REG_EDGE;
  assign wr_vec  = avl_write && avl_address == INTC_REG_VECTOR;
  always_comb begin
    enable_d = wr_set ? enable_q | wd : wr_clr ? enable_q & ~wd : enable_q;
    select_d = wr_sel ? wd : select_q;
    edge_d   = wr_edge ? wd : edge_q;
    // leaving edge mode also drops whatever the latch was holding
    clr      = (wr_vec ? wd : '0) | (wr_edge ? edge_q & ~wd : '0);
  end
  for (genvar i = 0; i < N; i++) begin : g_src
    intc_source u_src (
      .clk    (clk),
      .rst_n  (rst_n),
      .src_i  (sources[i]),
      .edge_i (edge_q[i]),
      .clr_i  (clr[i]),
      .raw_o  (raw[i])
    );
  end
  assign act_irq = raw & enable_q & ~select_q;
  assign act_fiq = raw & enable_q & select_q;
  // scan downward so the lowest-numbered active source is the last to overwrite
  always_comb begin
    vec_idx = '0;
    vec_hit = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (act_irq[i]) begin
        vec_idx = 5'(i);
        vec_hit = 1'b1;
      end
    end
  end
  assign vector = vec_hit ? {27'b0, vec_idx} : INTC_NO_VECTOR;
  assign rmux[INTC_REG_IRQ_STATUS] = 32'(act_irq);
  assign rmux[INTC_REG_FIQ_STATUS] = 32'(act_fiq);
  assign rmux[INTC_REG_RAW]        = 32'(raw);
  assign rmux[INTC_REG_ENABLE_SET] = 32'(enable_q);
  assign rmux[INTC_REG_ENABLE_CLR] = 32'(enable_q);
  assign rmux[INTC_REG_SELECT]     = 32'(select_q);
  assign rmux[INTC_REG_EDGE]       = 32'(edge_q);
  assign rmux[INTC_REG_VECTOR]     = vector;
  // reads sample pre-write state, so a colliding write is not visible yet
  assign rdata_d = avl_read ? rmux[avl_address] : rdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enable_q <= '0;
      select_q <= '0;
      edge_q   <= '0;
      rdata_q  <= '0;
      irq_q    <= 1'b0;
      fiq_q    <= 1'b0;
    end else begin
      enable_q <= enable_d;
      select_q <= select_d;
      edge_q   <= edge_d;
      rdata_q  <= rdata_d;
      irq_q    <= |act_irq;
      fiq_q    <= |act_fiq;
    end
  end
  assign avl_readdata = rdata_q;
  assign irq          = irq_q;
  assign fiq          = fiq_q;
endmodule

// File: tb/tb_intc_arm.sv
// tb_intc_arm: table-driven and sequence checks of intc_arm with a read-data scoreboard
module tb_intc_arm;
  import intc_arm_pkg::*;
  localparam int N = 8;
  logic         clk = 1'b0, rst_n = 1'b0;
  logic [N-1:0] sources = '0;
  logic [2:0]   avl_address = '0;
  logic         avl_read = 1'b0, avl_write = 1'b0;
  logic [31:0]  avl_writedata = '0, avl_readdata;
  logic         irq, fiq;
  int n_vec = 0, n_err = 0;
  typedef struct {logic [31:0] exp; string nm;} rd_t;
  rd_t  rq[$];
  logic rd_seen = 1'b0;
  typedef struct {
    logic wr; logic [2:0] a; logic [31:0] d; logic [7:0] src;
    logic [2:0] ra; logic [31:0] exp; logic eirq, efiq; string nm;
  } vec_t;
  vec_t tbl[12];
  always #5 clk = ~clk;
  intc_arm #(.NUM_SOURCES(N)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sources       (sources),
    .avl_address   (avl_address),
    .avl_read      (avl_read),
    .avl_write     (avl_write),
    .avl_writedata (avl_writedata),
    .avl_readdata  (avl_readdata),
    .irq           (irq),
    .fiq           (fiq)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    avl_write = 1'b1; avl_address = a; avl_writedata = d;
    tick();
    avl_write = 1'b0;
  endtask
  task automatic rd(input logic [2:0] a, input logic [31:0] e, input string nm);
    avl_read = 1'b1; avl_address = a;
    rq.push_back('{e, nm});
    tick();
    avl_read = 1'b0;
  endtask
  always @(posedge clk) rd_seen <= avl_read;
  always @(negedge clk) begin
    rd_t r;
    if (rd_seen) begin
      if (rq.size() == 0) chk("rd_unexpected", 32'd1, 32'd0);
      else begin
        r = rq.pop_front();
        chk(r.nm, avl_readdata, r.exp);
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    tbl[0]  = '{1'b1, INTC_REG_SELECT,     32'h8,         8'h00, INTC_REG_SELECT,     32'h8,         1'b0, 1'b0, "sel_rw"};
    tbl[1]  = '{1'b1, INTC_REG_ENABLE_SET, 32'h8,         8'h08, INTC_REG_FIQ_STATUS, 32'h8,         1'b0, 1'b1, "fiq_status"};
    tbl[2]  = '{1'b0, INTC_REG_RAW,        32'h0,         8'h08, INTC_REG_IRQ_STATUS, 32'h0,         1'b0, 1'b1, "fiq_irq_status"};
    tbl[3]  = '{1'b1, INTC_REG_ENABLE_CLR, 32'h8,         8'h08, INTC_REG_ENABLE_SET, 32'h0,         1'b0, 1'b0, "fiq_disable"};
    tbl[4]  = '{1'b1, INTC_REG_SELECT,     32'h0,         8'hA0, INTC_REG_RAW,        32'hA0,        1'b0, 1'b0, "masked_raw"};
    tbl[5]  = '{1'b1, INTC_REG_ENABLE_SET, 32'hA0,        8'hA0, INTC_REG_VECTOR,     32'd5,         1'b1, 1'b0, "prio_5"};
    tbl[6]  = '{1'b0, INTC_REG_RAW,        32'h0,         8'h80, INTC_REG_VECTOR,     32'd7,         1'b1, 1'b0, "prio_7"};
    tbl[7]  = '{1'b0, INTC_REG_RAW,        32'h0,         8'h00, INTC_REG_VECTOR,     INTC_NO_VECTOR, 1'b0, 1'b0, "prio_none"};
    tbl[8]  = '{1'b1, INTC_REG_ENABLE_SET, 32'hFFFF_FFFF, 8'h00, INTC_REG_ENABLE_CLR, 32'hFF,        1'b0, 1'b0, "enable_width"};
    tbl[9]  = '{1'b0, INTC_REG_RAW,        32'h0,         8'h01, INTC_REG_IRQ_STATUS, 32'h01,        1'b1, 1'b0, "irq_status"};
    tbl[10] = '{1'b1, INTC_REG_SELECT,     32'hFFFF_FFFF, 8'h01, INTC_REG_SELECT,     32'hFF,        1'b0, 1'b1, "select_width"};
    tbl[11] = '{1'b1, INTC_REG_ENABLE_CLR, 32'hFE,        8'h02, INTC_REG_FIQ_STATUS, 32'h0,         1'b0, 1'b0, "disabled_src"};
    #12;
    chk("rst_irq", irq, 0);
    chk("rst_fiq", fiq, 0);
    chk("rst_rdata", avl_readdata, 0);
    tick();
    rst_n = 1'b1;
    tick();
    rd(INTC_REG_ENABLE_SET, 32'h0, "rst_enable");
    rd(INTC_REG_VECTOR, INTC_NO_VECTOR, "rst_vector");
    // level source: irq on the third edge counting the sampling edge
    wr(INTC_REG_ENABLE_SET, 32'h1);
    sources[0] = 1'b1;
    tick(); chk("lvl_rise_e1", irq, 0);
    tick(); chk("lvl_rise_e2", irq, 0);
    tick(); chk("lvl_rise_e3", irq, 1);
    rd(INTC_REG_VECTOR, 32'd0, "lvl_vector");
    sources[0] = 1'b0;
    tick(); chk("lvl_fall_e1", irq, 1);
    tick(); chk("lvl_fall_e2", irq, 1);
    tick(); chk("lvl_fall_e3", irq, 0);
    // edge source latch and clear
    wr(INTC_REG_EDGE, 32'h4);
    wr(INTC_REG_ENABLE_SET, 32'h4);
    sources[2] = 1'b1; tick(); sources[2] = 1'b0;
    tick(5);
    rd(INTC_REG_RAW, 32'h4, "edge_raw");
    chk("edge_irq_hold", irq, 1);
    wr(INTC_REG_VECTOR, 32'h4);
    chk("clr_irq_e0", irq, 1);
    tick(); chk("clr_irq_e1", irq, 0);
    // clear on the same edge the rise reaches the latch
    sources[2] = 1'b1; tick(); sources[2] = 1'b0; tick();
    wr(INTC_REG_VECTOR, 32'h4);
    tick(2);
    chk("setwins_irq", irq, 1);
    rd(INTC_REG_RAW, 32'h4, "setwins_raw");
    wr(INTC_REG_EDGE, 32'h0);
    wr(INTC_REG_EDGE, 32'h4);
    tick();
    rd(INTC_REG_RAW, 32'h0, "edge_off_clr");
    wr(INTC_REG_ENABLE_CLR, 32'hFF);
    wr(INTC_REG_EDGE, 32'h0);
    tick(3);
    foreach (tbl[i]) begin
      sources = tbl[i].src;
      if (tbl[i].wr) wr(tbl[i].a, tbl[i].d);
      tick(4);
      rd(tbl[i].ra, tbl[i].exp, tbl[i].nm);
      chk({tbl[i].nm, "_irq"}, irq, tbl[i].eirq);
      chk({tbl[i].nm, "_fiq"}, fiq, tbl[i].efiq);
    end
    // read and write together: old value returned, write still lands
    avl_read = 1'b1; avl_write = 1'b1; avl_address = INTC_REG_SELECT; avl_writedata = 32'h3;
    rq.push_back('{32'hFF, "collide_old"});
    tick();
    avl_read = 1'b0; avl_write = 1'b0;
    rd(INTC_REG_SELECT, 32'h3, "collide_new");
    tick(3);
    chk("rd_hold", avl_readdata, 32'h3);
    // reset while an edge latch is pending
    sources = '0;
    wr(INTC_REG_SELECT, 32'h0);
    wr(INTC_REG_EDGE, 32'h4);
    wr(INTC_REG_ENABLE_SET, 32'h4);
    sources[2] = 1'b1; tick(); sources[2] = 1'b0;
    tick(5);
    chk("pre_rst_irq", irq, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_irq", irq, 0);
    chk("async_rst_fiq", fiq, 0);
    chk("async_rst_rdata", avl_readdata, 0);
    tick();
    rst_n = 1'b1;
    tick(2);
    rd(INTC_REG_ENABLE_SET, 32'h0, "post_rst_enable");
    rd(INTC_REG_SELECT, 32'h0, "post_rst_select");
    rd(INTC_REG_EDGE, 32'h0, "post_rst_edge");
    rd(INTC_REG_VECTOR, INTC_NO_VECTOR, "post_rst_vector");
    wr(INTC_REG_EDGE, 32'h4);
    tick();
    rd(INTC_REG_RAW, 32'h0, "post_rst_latch");
    chk("post_rst_irq", irq, 0);
    tick(2);
    chk("rd_queue_drained", rq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
